// File: rtl/ws2812_pkg.sv
// Shared types and defaults for the WS2812 chase controller and its frame timer.
package ws2812_pkg;

    typedef logic [23:0] color_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SWEEP   = 2'd1,
        ST_ADVANCE = 2'd2
    } chase_state_t;

    localparam int DEFAULT_NUM_LEDS = 8;
    localparam int DEFAULT_CLK_MHZ  = 12;

    // 20 ms frame period expressed in clock cycles
    function automatic int frame_ticks_default(input int clk_mhz);
        return clk_mhz * 20000;
    endfunction

endpackage

// File: rtl/ws2812_frame_timer.sv
// Free-running frame period divider: one tick every FRAME_TICKS cycles while enabled.
module ws2812_frame_timer
    import ws2812_pkg::*;
#(
    parameter int FRAME_TICKS = frame_ticks_default(DEFAULT_CLK_MHZ)
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(FRAME_TICKS - 1);

    logic [CW-1:0] count_reg;

    assign tick = enable && (count_reg == '0);

    // Disabling parks the counter at its reload value so re-enabling starts a full period
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= RELOAD;
        end else if (!enable || tick) begin
            count_reg <= RELOAD;
        end else begin
            count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_chase_ctrl.sv
// Frame scheduler for the ws2812 driver: periodic chase sweep plus host writes between sweeps.
module ws2812_chase_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS    = DEFAULT_NUM_LEDS,
    parameter int CLK_MHZ     = DEFAULT_CLK_MHZ,
    parameter int FRAME_TICKS = frame_ticks_default(CLK_MHZ)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] fg_color,
    input  logic [23:0] bg_color,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [7:0]  host_led,
    input  logic [23:0] host_rgb,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        write,
    output logic [7:0]  position,
    output logic        frame_done
);

    generate
        if (FRAME_TICKS < NUM_LEDS + 4) begin : g_bad_frame_ticks
            $error("ws2812_chase_ctrl: FRAME_TICKS must be at least NUM_LEDS+4");
        end
        if (NUM_LEDS < 2 || NUM_LEDS > 256) begin : g_bad_num_leds
            $error("ws2812_chase_ctrl: NUM_LEDS must be in 2..256");
        end
    endgenerate

    localparam logic [7:0] LAST_IDX  = 8'(NUM_LEDS - 1);
    localparam logic [8:0] LED_LIMIT = 9'(NUM_LEDS);

    logic tick;

    ws2812_frame_timer #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_frame_timer (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .tick  (tick)
    );

    chase_state_t state_reg, state_next;
    logic [7:0]   idx_reg, idx_next;
    logic [7:0]   position_reg, position_next;
    logic         write_reg, write_next;
    logic [7:0]   led_num_reg, led_num_next;
    color_t       rgb_data_reg, rgb_data_next;
    logic         frame_done_reg, frame_done_next;
    logic         host_in_range;

    assign host_ready    = (state_reg == ST_IDLE) && !tick;
    assign host_in_range = ({1'b0, host_led} < LED_LIMIT);

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        position_next   = position_reg;
        write_next      = 1'b0;
        led_num_next    = led_num_reg;
        rgb_data_next   = rgb_data_reg;
        frame_done_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (tick) begin
                    state_next = ST_SWEEP;
                    idx_next   = '0;
                end else if (host_valid && host_in_range) begin
                    // Out-of-range host slots are accepted but never reach the driver
                    write_next    = 1'b1;
                    led_num_next  = host_led;
                    rgb_data_next = host_rgb;
                end
            end
            ST_SWEEP: begin
                write_next    = 1'b1;
                led_num_next  = idx_reg;
                rgb_data_next = (idx_reg == position_reg) ? fg_color : bg_color;
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_ADVANCE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 8'd1;
                end
            end
            ST_ADVANCE: begin
                position_next   = (position_reg == LAST_IDX) ? 8'd0 : position_reg + 8'd1;
                frame_done_next = 1'b1;
                state_next      = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            position_reg   <= '0;
            write_reg      <= 1'b0;
            led_num_reg    <= '0;
            rgb_data_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            position_reg   <= position_next;
            write_reg      <= write_next;
            led_num_reg    <= led_num_next;
            rgb_data_reg   <= rgb_data_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign write      = write_reg;
    assign led_num    = led_num_reg;
    assign rgb_data   = rgb_data_reg;
    assign position   = position_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: doc/ws2812_chase_ctrl.md
# ws2812_chase_ctrl

Frame scheduler that drives the write port (`rgb_data`, `led_num`, `write`) of the `ws2812` LED driver. Once per frame period it sweeps every LED slot, writing a foreground colour at one moving "chase" position and a background colour everywhere else, then advances the position. Between sweeps a host port with a valid/ready handshake can write individual LEDs. It sits between the top level (or a UART/command decoder) and the `ws2812` instance.

## Interface
Parameters
- `NUM_LEDS`, 8: number of LED slots. Must match the driver. Range 2..256.
- `CLK_MHZ`, 12: clock frequency in MHz.
- `FRAME_TICKS`, `CLK_MHZ*20000`: clock cycles per frame (20 ms at default). Elaboration fails if `FRAME_TICKS < NUM_LEDS+4`.

Ports (clock and reset first)
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: frame timer runs while high.
- `fg_color`, in, 24: colour for the chase position (GRB order, as the driver expects).
- `bg_color`, in, 24: colour for all other slots.
- `host_valid`, in, 1: host write request.
- `host_ready`, out, 1: host request can be accepted this cycle (combinational).
- `host_led`, in, 8: target slot for the host write.
- `host_rgb`, in, 24: colour for the host write.
- `rgb_data`, out, 24: to the driver, registered.
- `led_num`, out, 8: to the driver, registered.
- `write`, out, 1: to the driver, registered, one-cycle pulse per write.
- `position`, out, 8: current chase index, registered.
- `frame_done`, out, 1: one-cycle pulse after each sweep completes.

## Operation
- **Frame timer.**
  - A down-counter `FRAME_TICKS-1`→0. `tick` is high in a cycle where the counter is 0 and `enable` is high; the counter then reloads.
  - While `enable` is low, the counter holds at its reload value and no tick occurs.
  - A sweep already in progress always completes.
- **States:** IDLE, SWEEP, ADVANCE.
  - **IDLE:** on `tick` → SWEEP with `idx`=0.
  - **SWEEP:** each cycle, issue one write with `led_num`=`idx` and `rgb_data`=(`idx`==`position`) ? `fg_color` : `bg_color`. After `idx`=`NUM_LEDS-1` → ADVANCE; otherwise `idx`+1.
  - **ADVANCE:** `position` ← (`position`==`NUM_LEDS-1`) ? 0 : `position`+1. Pulse `frame_done`, then → IDLE.
- **Host port.**
  - `host_ready` = (state==IDLE) && !`tick`. The tick has priority over the host in the same cycle.
  - An accept is `host_valid && host_ready`. It issues one write with `host_led`/`host_rgb`.
  - `host_led` ≥ `NUM_LEDS` is accepted and dropped: no `write` is issued.
  - Host writes persist only until the next sweep overwrites them.
- `fg_color` and `bg_color` are sampled in each SWEEP cycle. Changes mid-sweep take effect from the next slot.
- **Reset** (including mid-sweep) → IDLE, `position`=0, counter=`FRAME_TICKS-1`, `idx`=0, and all outputs 0: `write`, `led_num`, `rgb_data`, `position`, `frame_done`. The sweep is aborted with no further writes.

## Timing
- Host accept in cycle A → `write`=1 in cycle A+1 only, with `led_num`/`rgb_data` valid in that cycle.
- Tick in cycle T:
  - SWEEP occupies cycles T+1..T+N, where N=`NUM_LEDS`.
  - `write` is high in cycles T+2..T+N+1, carrying slots 0..N-1 in order, back-to-back.
  - ADVANCE occurs in T+N+1.
  - `frame_done`=1 and the new `position` appear in T+N+2. `host_ready` can return in T+N+2.
- Outside write cycles, `write`=0. `led_num` and `rgb_data` hold their last values.
- Successive ticks are exactly `FRAME_TICKS` cycles apart while `enable` is high.
- Because of the `FRAME_TICKS` constraint, a tick never lands outside IDLE.

## Structure
- Package `ws2812_pkg` holds:
  - the state enum (IDLE/SWEEP/ADVANCE);
  - the 24-bit colour typedef;
  - the shared `NUM_LEDS` default;
  - the `FRAME_TICKS` default expression.
- One sub-module: `ws2812_frame_timer`. Parameter `FRAME_TICKS`; ports `clk`, `reset`, `enable`, `tick`. The counter width is `$clog2(FRAME_TICKS)`.
- The sequencer and host mux stay in `ws2812_chase_ctrl`.

## Test plan
All scenarios use `NUM_LEDS`=8 and `FRAME_TICKS`=20.
- **Reset then enable:** fg=0x00FF00, bg=0x000010. First tick → 8 writes on consecutive cycles with `led_num` 0..7. Slot 0 gets 0x00FF00, slots 1..7 get 0x000010. Then `frame_done` pulses and `position`=1.
- **Position wrap:** run 8 frames → `position` sequence 1..7,0. Frame 8 writes fg to slot 7, and the following `position` is 0. Consecutive ticks are 20 cycles apart.
- **Host write in IDLE:** `host_led`=3, `host_rgb`=0xABCDEF, accepted in cycle A → `write`=1 in A+1 only, `led_num`=3, `rgb_data`=0xABCDEF. `host_led`=9 → accepted, no write.
- **Host/tick collision:** `host_valid` held high through a tick cycle → `host_ready`=0 in the tick cycle and through the sweep. The host write is issued after `frame_done`, and no sweep slot is skipped.
- **Enable low mid-sweep:** the sweep completes all 8 writes. No further tick occurs until `enable` rises again; the first tick then comes 20 cycles later.
- **Reset mid-sweep:** reset asserted after the 4th write → `write`=0 from the next cycle. All outputs are 0 and `position`=0. The next tick comes 20 cycles after reset is released.
